// File: rtl/flop.sv
// -----------------------------------------------------------------------------
// flop -- generic enable/reset register, reused by pipeline stages.
//
// Parameters
//   WIDTH       : data width in bits (must be >= 1)
//   RESET_VALUE : value loaded into Q while reset is asserted
//
// Ports
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; has priority over en
//   en    : load enable, active-high; when low the register holds
//   D     : data captured at an enabled edge
//   Q     : register contents, driven straight from the flop
//
// Q has no defined value until the first edge with reset or en high.
// -----------------------------------------------------------------------------
module flop #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "flop: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state selection: reset wins over enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (reset) begin
      q_d = RESET_VALUE;
    end else if (en) begin
      q_d = D;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: tb/tb_flop.sv
module tb_flop;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;

  int n_vec;
  int n_bad;

  flop #(.WIDTH(WIDTH)) u_a (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .D    (D),
    .Q    (q_a)
  );

  flop #(.WIDTH(WIDTH), .RESET_VALUE(32'hDEADBEEF)) u_b (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .D    (D),
    .Q    (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    en    = 1'b0;
    D     = '0;

    // Instance b resets to DEADBEEF; otherwise both follow the same D/en.
    vecs[0]  = '{"rst_load",      1'b1, 1'b0, 32'h1,        32'h0,        32'hDEADBEEF};
    vecs[1]  = '{"rst_release",   1'b0, 1'b0, 32'h1,        32'h0,        32'hDEADBEEF};
    vecs[2]  = '{"load_1",        1'b0, 1'b1, 32'h1,        32'h1,        32'h1};
    vecs[3]  = '{"load_2",        1'b0, 1'b1, 32'h2,        32'h2,        32'h2};
    vecs[4]  = '{"hold_a",        1'b0, 1'b0, 32'h4,        32'h2,        32'h2};
    vecs[5]  = '{"hold_b",        1'b0, 1'b0, 32'h4,        32'h2,        32'h2};
    vecs[6]  = '{"rst_en0",       1'b1, 1'b0, 32'h4,        32'h0,        32'hDEADBEEF};
    vecs[7]  = '{"reload_2",      1'b0, 1'b1, 32'h2,        32'h2,        32'h2};
    vecs[8]  = '{"rst_prio",      1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF};
    vecs[9]  = '{"rst_hold",      1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF};
    vecs[10] = '{"load_ones",     1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      reset = vecs[i].reset;
      en    = vecs[i].en;
      D     = vecs[i].d;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_a"}, q_a, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, q_b, vecs[i].exp_b);
    end

    // D toggling mid-cycle: Q follows only the value present at each edge.
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    D     = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    check("mid_first_edge", q_a, 32'hA5A5A5A5);
    #3;
    D = 32'h5A5A5A5A;
    #1;
    check("mid_between_edges", q_a, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    check("mid_second_edge", q_a, 32'h5A5A5A5A);

    // Data changing while disabled must not leak; enable later takes D at that edge.
    @(negedge clk);
    en = 1'b0;
    D  = 32'h11111111;
    @(posedge clk);
    #1;
    check("dis_no_leak", q_a, 32'h5A5A5A5A);
    #2;
    D = 32'h22222222;
    @(negedge clk);
    en = 1'b1;
    D  = 32'h33333333;
    @(posedge clk);
    #1;
    check("en_takes_edge_d", q_a, 32'h33333333);

    // Reset and enable changes between edges take effect only at the next edge.
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_no_effect", q_a, 32'h33333333);
    check("rst_mid_no_effect_b", q_b, 32'h33333333);
    @(posedge clk);
    #1;
    check("rst_at_edge", q_a, 32'h0);
    check("rst_at_edge_b", q_b, 32'hDEADBEEF);
    #2;
    reset = 1'b0;
    en    = 1'b0;
    D     = 32'h44444444;
    #1;
    check("rst_deassert_mid", q_b, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    check("rst_deassert_hold", q_b, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) begin
      $display("TEST PASSED");
      $finish;
    end else begin
      $fatal(1, "flop bench detected errors");
    end
  end

endmodule
